config_port_arbiter: RTL
========================

Name: config_port_arbiter

Overview:
- Parametrised successor to the fixed three-level configuration-source mux in the eFPGA configuration block.
- Arbitrates NUM_PORTS configuration sources onto the single ConfigWriteData/ConfigWriteStrobe stream that feeds ConfigFSM. Typical sources are CPU self-write, bitbang, UART and JTAG.
- Replaces combinational priority muxing with a registered, non-preemptive grant FSM. Adds a per-session FSM_Reset pulse, an idle timeout, a word counter and a dropped-strobe flag.
- All inputs must already be synchronous to CLK; the JTAG/tck crossing is done upstream.

Parameters:
- NUM_PORTS, 4, number of configuration sources; index NUM_PORTS-1 has the highest priority.
- DATA_WIDTH, 32, configuration word width.
- TIMEOUT_CYCLES, 65535, owner-idle cycles before forced release; 0 disables the timeout.
- CNT_WIDTH, 16, width of the session word counter.

Ports:
- CLK  in  1  clock, all logic rising-edge.
- resetn  in  1  reset; asynchronous assert, active-low.
- PortActive  in  NUM_PORTS  per-source session-active request.
- PortStrobe  in  NUM_PORTS  per-source write strobe, single-cycle pulses.
- PortData  in  NUM_PORTS*DATA_WIDTH  packed words; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ConfigWriteData  out  DATA_WIDTH  registered word to ConfigFSM.
- ConfigWriteStrobe  out  1  registered strobe to ConfigFSM.
- FSM_Reset  out  1  one-cycle pulse at each new grant.
- Grant  out  NUM_PORTS  one-hot current owner; all zeros when there is no owner.
- WordCount  out  CNT_WIDTH  words forwarded in the current session.
- DropFlag  out  1  sticky flag: a strobe was seen from a non-owner.
- ReceiveLED  out  1  toggles on every forwarded word.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
- States: IDLE, LOCK, GUARD.
- IDLE:
  - If any PortActive bit is set, choose the highest set index p.
  - Next cycle: state LOCK, Grant = onehot(p), FSM_Reset = 1 for exactly that cycle, WordCount = 0, timeout counter = 0.
  - Strobes arriving in IDLE are not forwarded and set DropFlag.
- LOCK, forwarding:
  - Owner strobe in cycle t produces ConfigWriteStrobe = 1 and ConfigWriteData = owner word in cycle t+1. Latency is exactly 1.
  - ConfigWriteData holds its last value when no strobe is forwarded.
  - Each forwarded word: WordCount += 1, saturating at all-ones; ReceiveLED toggles; timeout counter clears.
- LOCK, non-owners:
  - Higher-priority requests do not preempt the owner (unless the optional feature below is compiled in).
  - Any non-owner strobe sets DropFlag and is discarded.
- LOCK, release:
  - Owner PortActive low → GUARD.
  - Timeout counter reaching TIMEOUT_CYCLES (when nonzero) → GUARD.
  - A strobe in the same cycle as the release condition is still forwarded.
- GUARD:
  - Lasts exactly one cycle; Grant = 0, no forwarding; then IDLE.
  - Re-arbitration happens in IDLE. The minimum gap between sessions is therefore 2 cycles.
  - A timed-out owner that still holds PortActive may regain the grant. This restarts the session and pulses FSM_Reset.
- Simultaneous requests: highest index wins; ties are impossible.
- Reset mid-session: immediate return to IDLE, all outputs 0, and no FSM_Reset pulse is generated.
- DropFlag clears only on reset.
- ConfigWriteStrobe is never high in two consecutive cycles unless the owner strobes on consecutive cycles, which is legal.

Optional Feature:
- Macro: CFG_ARB_PREEMPT_EN.
- Defined:
  - In LOCK, PortActive from any index above the owner forces LOCK → GUARD on the next cycle.
  - The owner's strobe in that cycle is still forwarded.
  - The higher index is then granted through IDLE as usual.
- Undefined: strictly non-preemptive as described under Behaviour.

Decomposition:
- Shared package cfg_arb_pkg holds:
  - the state enum (IDLE/LOCK/GUARD);
  - the priority-encoder function, highest-set-bit to index;
  - a default DATA_WIDTH constant shared with ConfigFSM.
- One sub-module, cfg_arb_timeout: loadable/clearable idle counter with a terminal flag, omitted when TIMEOUT_CYCLES = 0.

Test Plan:
1. Idle entry: PortActive = 4'b0010; three strobes with words 0xA5A5_0001..3 → Grant = 0010; FSM_Reset single pulse; words appear at t+1; WordCount = 3; ReceiveLED ends at 1.
2. Non-preemption: port 1 owns the grant; port 3 raises PortActive and strobes 0xDEAD_BEEF → not forwarded, DropFlag = 1. Port 1 drops active → GUARD, then IDLE, then Grant = 1000 with FSM_Reset pulse.
3. Simultaneous requests: PortActive = 4'b1011 from IDLE → Grant = 1000.
4. Timeout: TIMEOUT_CYCLES = 8; owner stays active with no strobes → after 8 cycles GUARD, then re-grant of the same port with a fresh FSM_Reset pulse and WordCount = 0.
5. Reset mid-session: assert resetn = 0 during a LOCK forward → all outputs 0 asynchronously; after release, state is IDLE.
6. Preemption, with CFG_ARB_PREEMPT_EN defined: port 0 owns; port 2 raises active → owner's same-cycle strobe is forwarded; Grant = 0100 three cycles later.

Source files
------------

// File: rtl/cfg_arb_pkg.sv
// Shared types and helpers for the configuration-port arbiter and ConfigFSM.
package cfg_arb_pkg;

    localparam int unsigned CfgDataWidth = 32;
    localparam int unsigned CfgMaxPorts  = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLock,
        StGuard
    } cfg_arb_state_e;

    // Highest set bit wins; returns 0 for an all-zero vector.
    function automatic int unsigned prio_enc(input logic [CfgMaxPorts-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < CfgMaxPorts; i++) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cfg_arb_timeout.sv
// Owner-idle counter: expires after Limit consecutive enabled cycles, cleared on clr.
module cfg_arb_timeout #(
    parameter int unsigned Limit = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired = en && (cnt_q == CntW'(Limit - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || expired) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/config_port_arbiter.sv
// Registered, non-preemptive arbiter of NUM_PORTS config sources onto the ConfigFSM write stream.
// Optional preemption by higher-index requesters is enabled with `define CFG_ARB_PREEMPT_EN.
module config_port_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned DATA_WIDTH     = CfgDataWidth,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                            CLK,
    input  logic                            resetn,
    input  logic [NUM_PORTS-1:0]            PortActive,
    input  logic [NUM_PORTS-1:0]            PortStrobe,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] PortData,
    output logic [DATA_WIDTH-1:0]           ConfigWriteData,
    output logic                            ConfigWriteStrobe,
    output logic                            FSM_Reset,
    output logic [NUM_PORTS-1:0]            Grant,
    output logic [CNT_WIDTH-1:0]            WordCount,
    output logic                            DropFlag,
    output logic                            ReceiveLED
);

    localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    cfg_arb_state_e         state_q, state_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   strobe_q, strobe_d;
    logic                   fsm_reset_q, fsm_reset_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   drop_q, drop_d;
    logic                   led_q, led_d;

    logic [IdxW-1:0]        req_idx;
    logic [DATA_WIDTH-1:0]  owner_word;
    logic                   owner_strobe;
    logic                   other_strobe;
    logic                   owner_active;
    logic                   preempt;
    logic                   timed_out;

    assign req_idx      = IdxW'(prio_enc(CfgMaxPorts'(PortActive)));
    assign owner_word   = PortData[owner_q*DATA_WIDTH +: DATA_WIDTH];
    assign owner_strobe = |(PortStrobe & grant_q);
    assign other_strobe = |(PortStrobe & ~grant_q);
    assign owner_active = |(PortActive & grant_q);

`ifdef CFG_ARB_PREEMPT_EN
    always_comb begin
        preempt = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (i > 32'(owner_q) && PortActive[i]) preempt = 1'b1;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    if (TIMEOUT_CYCLES != 0) begin : g_timeout
        logic to_en;
        logic to_clr;
        // Count only idle owner cycles; any forwarded word restarts the window.
        assign to_en  = (state_q == StLock) && !owner_strobe;
        assign to_clr = (state_q != StLock) || owner_strobe;

        cfg_arb_timeout #(
            .Limit(TIMEOUT_CYCLES)
        ) u_timeout (
            .clk    (CLK),
            .rst_n  (resetn),
            .clr    (to_clr),
            .en     (to_en),
            .expired(timed_out)
        );
    end else begin : g_no_timeout
        assign timed_out = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        data_d      = data_q;
        strobe_d    = 1'b0;
        fsm_reset_d = 1'b0;
        count_d     = count_q;
        drop_d      = drop_q;
        led_d       = led_q;

        case (state_q)
            StIdle: begin
                if (|PortStrobe) drop_d = 1'b1;
                if (|PortActive) begin
                    state_d     = StLock;
                    owner_d     = req_idx;
                    grant_d     = NUM_PORTS'(1) << req_idx;
                    fsm_reset_d = 1'b1;
                    count_d     = '0;
                end
            end
            StLock: begin
                if (other_strobe) drop_d = 1'b1;
                // Forwarding is independent of release so a last-cycle word is never lost.
                if (owner_strobe) begin
                    strobe_d = 1'b1;
                    data_d   = owner_word;
                    led_d    = ~led_q;
                    if (count_q != '1) count_d = count_q + 1'b1;
                end
                if (!owner_active || timed_out || preempt) begin
                    state_d = StGuard;
                    grant_d = '0;
                end
            end
            StGuard: begin
                if (|PortStrobe) drop_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            grant_q     <= '0;
            data_q      <= '0;
            strobe_q    <= 1'b0;
            fsm_reset_q <= 1'b0;
            count_q     <= '0;
            drop_q      <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            fsm_reset_q <= fsm_reset_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            led_q       <= led_d;
        end
    end

    assign ConfigWriteData   = data_q;
    assign ConfigWriteStrobe = strobe_q;
    assign FSM_Reset         = fsm_reset_q;
    assign Grant             = grant_q;
    assign WordCount         = count_q;
    assign DropFlag          = drop_q;
    assign ReceiveLED        = led_q;

endmodule
